cpu_trace_recorder: RTL and testbench
=====================================

Name: cpu_trace_recorder

Overview:
Synthesizable on-chip successor to the CPU bench's per-cycle PC/register dump. Samples the CPU's PC and register-file write port every cycle into a parametrised trace FIFO, stopping after a configurable cycle budget. Records are drained through a valid/ready port by a host, UART bridge or bench. Sits beside the CPU top and taps the PC register output and the register-file write-port signals.

Parameters:
PC_W, 32, width of pc_i and rd_pc_o
DATA_W, 32, register-file data width
REG_AW, 5, register address width
DEPTH, 64, trace FIFO entries (power of two, >=2)
CNT_W, 16, cycle counter width
MAX_CYCLES, 30, capture budget in cycles; 0 = unlimited
WRITES_ONLY, 0, 0 = record every RUN cycle; 1 = record only cycles with an effective register write

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  level; enables capture
clear_i  in  1  synchronous pulse; flush the FIFO and return to IDLE
pc_i  in  PC_W  current PC
rf_we_i  in  1  register-file write enable
rf_waddr_i  in  REG_AW  write address
rf_wdata_i  in  DATA_W  write data
rd_valid_o  out  1  head record available
rd_ready_i  in  1  consumer accepts the head record
rd_cycle_o  out  CNT_W  cycle index of the head record
rd_pc_o  out  PC_W  PC of the head record
rd_we_o  out  1  effective write flag of the head record
rd_waddr_o  out  REG_AW  head record write address
rd_wdata_o  out  DATA_W  head record write data
count_o  out  log2(DEPTH)+1  FIFO occupancy
cycle_o  out  CNT_W  captured-cycle counter
overflow_o  out  1  sticky; a record was dropped
dropped_o  out  CNT_W  number of dropped records, saturating
done_o  out  1  capture budget exhausted

Behaviour:
- Reset (rst_i=0, async): state IDLE. FIFO empty. All outputs 0, including the rd_* data fields.
- States:
  - IDLE: on a clock edge with start_i=1, go to RUN. No capture on that edge.
  - RUN: on each edge with start_i=1, capture one cycle.
    - cycle_o increments after every captured cycle, including ones not recorded under WRITES_ONLY.
    - start_i=0 pauses: no capture, cycle_o holds, state stays RUN.
    - When MAX_CYCLES!=0 and cycle_o reaches MAX_CYCLES-1 at capture, go to DONE after that capture. done_o=1 from the next cycle.
  - DONE: no further capture. FIFO still drains. Exit only via clear_i or reset.
- clear_i (any state, priority over capture and pop):
  - FIFO emptied; cycle_o, overflow_o, dropped_o and done_o cleared; go to IDLE.
- Record contents: {cycle_o, pc_i, eff_we, rf_waddr_i, rf_wdata_i}.
  - eff_we = rf_we_i && rf_waddr_i!=0. Writes to r0 count as non-writes.
  - When eff_we=0, the stored waddr and wdata are 0.
  - WRITES_ONLY=1 pushes only when eff_we=1.
- FIFO timing:
  - Registered, no fall-through. A record pushed on edge N is visible with rd_valid_o=1 after edge N.
  - Pop occurs on an edge with rd_valid_o && rd_ready_i.
  - Outputs show the head record. rd_* data is don't-care while rd_valid_o=0.
- Full: a push while count_o==DEPTH with no simultaneous pop is dropped. overflow_o is set (sticky) and dropped_o increments, saturating at all-ones. The oldest data is preserved.
- Simultaneous push and pop when full: both accepted, count unchanged, no overflow.
- Simultaneous push and pop when empty: the pop is ignored (rd_valid_o=0), the push is accepted, count becomes 1.
- Pointers wrap modulo DEPTH. count_o ranges 0..DEPTH.
- cycle_o wraps at 2^CNT_W only when MAX_CYCLES=0.
- Reset asserted mid-RUN: immediate clear per the reset rule. Contents are lost.

Test Plan:
- Basic capture: reset, start_i=1 held, PC stepping by 4 from 0, MAX_CYCLES=30, rd_ready_i=1 -> 30 records, cycle 0..29, PC 0..116. done_o=1 from the cycle after capture 29. No further records.
- r0 filter: rf_we_i=1, waddr=0, wdata=5 at cycle 3 -> record 3 has we=0, waddr=0, wdata=0. With WRITES_ONLY=1 -> no record for cycle 3.
- Overflow: DEPTH=4, rd_ready_i=0, 6 cycles captured -> count_o=4, overflow_o=1, dropped_o=2. Drained records are cycles 0..3.
- Full plus simultaneous pop: FIFO at 4/4, rd_ready_i=1 during a capture cycle -> count stays 4, overflow_o=0, head advances by one.
- Pause and clear: start_i low for 3 cycles mid-run -> cycle_o frozen, no pushes. clear_i pulse -> count_o=0, cycle_o=0, state IDLE. Next start_i begins again at cycle 0.
- Async reset mid-run: drop rst_i between clock edges -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_trace_recorder.sv
// cpu_trace_recorder: samples PC and register-file writes each cycle into a drainable trace FIFO
// with a cycle budget, overflow accounting and a valid/ready read port.
module cpu_trace_recorder #(
    parameter int PC_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH = 64,
    parameter int CNT_W = 16,
    parameter int MAX_CYCLES = 30,
    parameter int WRITES_ONLY = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              rf_we_i,
    input  logic [REG_AW-1:0] rf_waddr_i,
    input  logic [DATA_W-1:0] rf_wdata_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [CNT_W-1:0]  rd_cycle_o,
    output logic [PC_W-1:0]   rd_pc_o,
    output logic              rd_we_o,
    output logic [REG_AW-1:0] rd_waddr_o,
    output logic [DATA_W-1:0] rd_wdata_o,
    output logic [AW:0]       count_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  dropped_o,
    output logic              done_o
);
    localparam int REC_W = CNT_W + PC_W + 1 + REG_AW + DATA_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             eff_we, capture, push, pop, full, accept, drop;
    logic [REC_W-1:0] rec;

    // Writes to r0 are architecturally void, so they are stored as non-writes with zeroed fields.
    assign eff_we  = rf_we_i && rf_waddr_i != '0;
    assign capture = state == RUN && start_i && !clear_i;
    assign push    = capture && (WRITES_ONLY == 0 || eff_we);
    assign pop     = rd_valid_o && rd_ready_i;
    assign full    = count_o == (AW+1)'(DEPTH);
    assign accept  = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign rec     = {cycle_o, pc_i, eff_we, eff_we ? rf_waddr_i : {REG_AW{1'b0}},
                      eff_we ? rf_wdata_i : {DATA_W{1'b0}}};

    assign rd_valid_o = count_o != '0;
    assign done_o     = state == DONE;
    // Gating by valid keeps the head fields at zero out of reset without clearing the array.
    assign {rd_cycle_o, rd_pc_o, rd_we_o, rd_waddr_o, rd_wdata_o} = rd_valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            cycle_o    <= '0;
            overflow_o <= 1'b0;
            dropped_o  <= '0;
        end else if (clear_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            cycle_o    <= '0;
            overflow_o <= 1'b0;
            dropped_o  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count_o <= count_o + (AW+1)'(accept) - (AW+1)'(pop);
            if (drop) begin
                overflow_o <= 1'b1;
                if (!(&dropped_o)) dropped_o <= dropped_o + 1'b1;
            end
            if (capture) begin
                cycle_o <= cycle_o + 1'b1;
                if (MAX_CYCLES != 0 && cycle_o == LAST) state <= DONE;
            end
            if (state == IDLE && start_i) state <= RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) mem[wr_ptr] <= rec;
    end
endmodule

// File: tb/tb_cpu_trace_recorder.sv
// tb_cpu_trace_recorder: scoreboard bench running a record-everything and a writes-only recorder
// side by side against a queue-based reference model.
module tb_cpu_trace_recorder;
    localparam int DEPTH = 4;
    localparam int MAXC = 30;

    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rec_t;

    logic clk_i = 0, rst_i = 1, start_i = 0, clear_i = 0, rf_we_i = 0, rd_ready_i = 0;
    logic [31:0] pc_i = 0, rf_wdata_i = 0;
    logic [4:0]  rf_waddr_i = 0;

    logic        rd_valid_o [2], rd_we_o [2], overflow_o [2], done_o [2];
    logic [15:0] rd_cycle_o [2], cycle_o [2], dropped_o [2];
    logic [31:0] rd_pc_o [2], rd_wdata_o [2];
    logic [4:0]  rd_waddr_o [2];
    logic [2:0]  count_o [2];

    int errors = 0, checks = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_trace_recorder #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC), .WRITES_ONLY(g)) u_dut (
            .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i), .pc_i(pc_i),
            .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i),
            .rd_valid_o(rd_valid_o[g]), .rd_ready_i(rd_ready_i), .rd_cycle_o(rd_cycle_o[g]),
            .rd_pc_o(rd_pc_o[g]), .rd_we_o(rd_we_o[g]), .rd_waddr_o(rd_waddr_o[g]),
            .rd_wdata_o(rd_wdata_o[g]), .count_o(count_o[g]), .cycle_o(cycle_o[g]),
            .overflow_o(overflow_o[g]), .dropped_o(dropped_o[g]), .done_o(done_o[g]));
    end

    always #5 clk_i = ~clk_i;

    // Reference model: phase 0 idle, 1 running, 2 budget spent; FIFO tracked as an occupancy number.
    int mst [2], mcyc [2], mcnt [2], mdrop [2];
    bit movf [2];
    rec_t sb0 [$], sb1 [$];

    function automatic int sb_size(int w);
        return w == 0 ? sb0.size() : sb1.size();
    endfunction

    function automatic rec_t sb_pop(int w);
        if (w == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    task automatic sb_push(int w, rec_t r);
        if (w == 0) sb0.push_back(r); else sb1.push_back(r);
    endtask

    task automatic model_reset(int w);
        mst[w] = 0; mcyc[w] = 0; mcnt[w] = 0; mdrop[w] = 0; movf[w] = 0;
        if (w == 0) sb0.delete(); else sb1.delete();
    endtask

    task automatic chk(string name, int w, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, w, got, exp, $time);
        end
    endtask

    // Applies the rules for the clock edge that has just happened, using the inputs held across it.
    task automatic model_step();
        for (int w = 0; w < 2; w++) begin
            bit pop, cap, eff, push;
            rec_t r;
            if (clear_i) begin
                model_reset(w);
                continue;
            end
            pop  = mcnt[w] > 0 && rd_ready_i;
            cap  = mst[w] == 1 && start_i;
            eff  = rf_we_i && rf_waddr_i != 0;
            push = cap && (w == 0 || eff);
            r = '{cyc: 16'(mcyc[w]), pc: pc_i, we: eff, waddr: eff ? rf_waddr_i : 5'd0,
                  wdata: eff ? rf_wdata_i : 32'd0};
            if (push && mcnt[w] == DEPTH && !pop) begin
                movf[w] = 1;
                if (mdrop[w] < 65535) mdrop[w]++;
            end else if (push) begin
                sb_push(w, r);
                mcnt[w]++;
            end
            if (pop) mcnt[w]--;
            if (cap) begin
                if (mcyc[w] == MAXC - 1) mst[w] = 2;
                mcyc[w]++;
            end else if (mst[w] == 0 && start_i) mst[w] = 1;
        end
    endtask

    task automatic check_status();
        for (int w = 0; w < 2; w++) begin
            chk("count", w, count_o[w], mcnt[w]);
            chk("valid", w, rd_valid_o[w], mcnt[w] > 0);
            chk("cycle", w, cycle_o[w], mcyc[w]);
            chk("overflow", w, overflow_o[w], movf[w]);
            chk("dropped", w, dropped_o[w], mdrop[w]);
            chk("done", w, done_o[w], mst[w] == 2);
        end
    endtask

    task automatic check_zero();
        for (int w = 0; w < 2; w++) begin
            chk("reset_status", w, {count_o[w], cycle_o[w], overflow_o[w], dropped_o[w], done_o[w],
                rd_valid_o[w], rd_we_o[w], rd_waddr_o[w]}, 0);
            chk("reset_data", w, {rd_cycle_o[w], rd_pc_o[w], rd_wdata_o[w]}, 0);
        end
    endtask

    task automatic cyc(bit st, bit clr, bit rdy, bit we, logic [4:0] wa, logic [31:0] wd);
        start_i = st; clear_i = clr; rd_ready_i = rdy; rf_we_i = we; rf_waddr_i = wa; rf_wdata_i = wd;
        @(posedge clk_i);
        #1;
        model_step();
        check_status();
    endtask

    task automatic do_reset();
        #2 rst_i = 0;
        #1 check_zero();
        for (int w = 0; w < 2; w++) model_reset(w);
        @(negedge clk_i);
        #1 rst_i = 1;
    endtask

    // Monitor: a head presented with ready high is consumed on the next edge.
    always @(negedge clk_i) begin
        for (int w = 0; w < 2; w++) begin
            if (rst_i && rd_valid_o[w] && rd_ready_i) begin
                rec_t got, exp;
                got = '{rd_cycle_o[w], rd_pc_o[w], rd_we_o[w], rd_waddr_o[w], rd_wdata_o[w]};
                if (sb_size(w) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record[%0d] got=%0h expected=none at %0t", w, got, $time);
                end else begin
                    exp = sb_pop(w);
                    chk("record", w, got, exp);
                end
            end
        end
    end

    initial begin
        #1 rst_i = 0;
        #2 check_zero();
        for (int w = 0; w < 2; w++) model_reset(w);
        @(negedge clk_i);
        #1 rst_i = 1;
        // Basic capture over the full budget, with an r0 write at cycle 3.
        cyc(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < MAXC; k++) begin
            pc_i = 32'(4 * k);
            cyc(1, 0, 1, k == 3 || k % 5 == 1, k == 3 ? 5'd0 : 5'(k), k == 3 ? 32'd5 : 32'(k * 7));
        end
        repeat (3) cyc(1, 0, 1, 1, 5'd9, 32'h99);
        cyc(0, 1, 1, 0, 0, 0);
        // Overflow with the consumer stalled, then a push and pop together while full.
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            pc_i = 32'(100 + k);
            cyc(1, 0, 0, 1, 5'(k + 1), 32'(k));
        end
        pc_i = 32'h200;
        cyc(1, 0, 1, 1, 5'd7, 32'd77);
        repeat (3) cyc(0, 0, 0, 1, 5'd8, 32'd88);
        repeat (6) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        // Randomised traffic with occasional clears and one asynchronous reset mid-run.
        for (int i = 0; i < 700; i++) begin
            if (i == 350) do_reset();
            pc_i = $urandom;
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
